// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared sizes, 2-bit counter encodings and counter update helper
package branch_predictor_pkg;
  localparam int BHT_ENTRIES = 64;
  localparam int BHT_IDX_W = 6;
  localparam int BTB_ENTRIES = 16;
  localparam int BTB_IDX_W = 4;
  localparam int BTB_TAG_W = 26;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    return taken ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_predictor_btb_table.sv
// btb_table: direct-mapped branch target buffer, async read, sync write, sync clear of valid bits
//   clk, rst          : clock, sync active-high clear
//   i_rd_idx          : fetch lookup index -> o_rd_valid/o_rd_tag/o_rd_target
//   i_we, i_wr_idx    : write enable and index
//   i_wr_tag/target   : entry contents written with valid=1
module btb_table
  import branch_predictor_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BTB_IDX_W-1:0] i_rd_idx,
  output logic                 o_rd_valid,
  output logic [BTB_TAG_W-1:0] o_rd_tag,
  output logic [31:0]          o_rd_target,
  input  logic                 i_we,
  input  logic [BTB_IDX_W-1:0] i_wr_idx,
  input  logic [BTB_TAG_W-1:0] i_wr_tag,
  input  logic [31:0]          i_wr_target
);
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [BTB_TAG_W-1:0]   r_tag    [BTB_ENTRIES];
  logic [31:0]            r_target [BTB_ENTRIES];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx]  <= 1'b1;
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end
  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_tag    = r_tag[i_rd_idx];
  assign o_rd_target = r_target[i_rd_idx];
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 64-entry 2-bit BHT + 16-entry BTB predictor with EX-stage resolve and mispredict counter
//   fetch : if_pc -> pred_taken, pred_target, pred_index (combinational)
//   ex    : ex_branch_valid, ex_pc, ex_target, ex_taken, ex_pred_taken/target/index
//   out   : pridictor_wrong, correct_pc (combinational), mispredict_count (saturating)
//   GSHARE_PREDICTOR_EN: when defined, BHT index is if_pc[7:2] XOR a 6-bit global history
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_pc,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic [BHT_IDX_W-1:0] pred_index,
  input  logic                 ex_branch_valid,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_target,
  input  logic                 ex_taken,
  input  logic                 ex_pred_taken,
  input  logic [31:0]          ex_pred_target,
  input  logic [BHT_IDX_W-1:0] ex_pred_index,
  output logic                 pridictor_wrong,
  output logic [31:0]          correct_pc,
  output logic [15:0]          mispredict_count
);
  logic [1:0]           r_bht [BHT_ENTRIES];
  logic [15:0]          r_cnt;
  logic [BHT_IDX_W-1:0] w_idx;
  logic                 w_btb_valid;
  logic [BTB_TAG_W-1:0] w_btb_tag;
  logic [31:0]          w_btb_target;
`ifdef GSHARE_PREDICTOR_EN
  logic [BHT_IDX_W-1:0] r_ghr;
  always_ff @(posedge clk) begin
    if (rst) r_ghr <= '0;
    else if (ex_branch_valid) r_ghr <= {r_ghr[BHT_IDX_W-2:0], ex_taken};
  end
  assign w_idx = if_pc[7:2] ^ r_ghr;
`else
  assign w_idx = if_pc[7:2];
`endif
  btb_table u_btb (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (if_pc[5:2]),
    .o_rd_valid (w_btb_valid),
    .o_rd_tag   (w_btb_tag),
    .o_rd_target(w_btb_target),
    .i_we       (ex_branch_valid & ex_taken),
    .i_wr_idx   (ex_pc[5:2]),
    .i_wr_tag   (ex_pc[31:6]),
    .i_wr_target(ex_target)
  );
  always_comb begin
    pred_index      = w_idx;
    pred_taken      = w_btb_valid && w_btb_tag == if_pc[31:6] && r_bht[w_idx][1];
    pred_target     = pred_taken ? w_btb_target : if_pc + 32'd4;
    pridictor_wrong = !rst && ex_branch_valid &&
                      (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
    correct_pc      = ex_taken ? ex_target : ex_pc + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bht <= '{default: WNT};
      r_cnt <= '0;
    end else begin
      if (ex_branch_valid) r_bht[ex_pred_index] <= ctr_next(r_bht[ex_pred_index], ex_taken);
      if (pridictor_wrong && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end
  assign mispredict_count = r_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven directed checks of prediction, resolve, reset and counter saturation
module tb_branch_predictor;
  typedef struct {
    logic [31:0] if_pc;
    logic        v;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        ptk;
    logic [31:0] ptgt;
    logic [5:0]  pidx;
    logic        e_pt;
    logic [31:0] e_tgt;
    logic [5:0]  e_idx;
    logic        e_wrong;
    logic [31:0] e_cpc;
    logic [15:0] e_cnt;
  } vec_t;
  logic        clk = 0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [5:0]  pred_index;
  logic        ex_branch_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [5:0]  ex_pred_index;
  logic        pridictor_wrong;
  logic [31:0] correct_pc;
  logic [15:0] mispredict_count;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [16];
  branch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .pred_index      (pred_index),
    .ex_branch_valid (ex_branch_valid),
    .ex_pc           (ex_pc),
    .ex_target       (ex_target),
    .ex_taken        (ex_taken),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_target  (ex_pred_target),
    .ex_pred_index   (ex_pred_index),
    .pridictor_wrong (pridictor_wrong),
    .correct_pc      (correct_pc),
    .mispredict_count(mispredict_count)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic [31:0] ipc, input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic tk, input logic ptk, input logic [31:0] ptgt, input logic [5:0] pidx,
                              input logic ept, input logic [31:0] etgt, input logic [5:0] eidx, input logic ew,
                              input logic [31:0] ecpc, input logic [15:0] ecnt);
    vec_t r;
    r.if_pc = ipc; r.v = v; r.pc = pc; r.tgt = tgt; r.tk = tk; r.ptk = ptk; r.ptgt = ptgt; r.pidx = pidx;
    r.e_pt = ept; r.e_tgt = etgt; r.e_idx = eidx; r.e_wrong = ew; r.e_cpc = ecpc; r.e_cnt = ecnt;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    if_pc = t.if_pc; ex_branch_valid = t.v; ex_pc = t.pc; ex_target = t.tgt; ex_taken = t.tk;
    ex_pred_taken = t.ptk; ex_pred_target = t.ptgt; ex_pred_index = t.pidx;
  endtask
  initial begin
    vecs[0]  = mk(32'h40, 0, 32'h0,  32'h0,   0, 0, 32'h0,   6'h00, 0, 32'h44,  6'h10, 0, 32'h4,   16'd0);
    vecs[1]  = mk(32'h40, 1, 32'h40, 32'h100, 1, 0, 32'h0,   6'h10, 0, 32'h44,  6'h10, 1, 32'h100, 16'd0);
    vecs[2]  = mk(32'h40, 1, 32'h40, 32'h100, 1, 0, 32'h0,   6'h10, 1, 32'h100, 6'h10, 1, 32'h100, 16'd1);
    vecs[3]  = mk(32'h40, 0, 32'h40, 32'h300, 1, 0, 32'h0,   6'h10, 1, 32'h100, 6'h10, 0, 32'h300, 16'd2);
    vecs[4]  = mk(32'h40, 1, 32'h40, 32'h100, 1, 1, 32'h100, 6'h10, 1, 32'h100, 6'h10, 0, 32'h100, 16'd2);
    vecs[5]  = mk(32'h40, 1, 32'h40, 32'h100, 1, 1, 32'h100, 6'h10, 1, 32'h100, 6'h10, 0, 32'h100, 16'd2);
    vecs[6]  = mk(32'h40, 1, 32'h40, 32'h100, 1, 1, 32'h100, 6'h10, 1, 32'h100, 6'h10, 0, 32'h100, 16'd2);
    vecs[7]  = mk(32'h40, 1, 32'h40, 32'h100, 1, 1, 32'h100, 6'h10, 1, 32'h100, 6'h10, 0, 32'h100, 16'd2);
    vecs[8]  = mk(32'h40, 1, 32'h40, 32'h100, 0, 1, 32'h100, 6'h10, 1, 32'h100, 6'h10, 1, 32'h44,  16'd2);
    vecs[9]  = mk(32'h40, 0, 32'h0,  32'h0,   0, 0, 32'h0,   6'h00, 1, 32'h100, 6'h10, 0, 32'h4,   16'd3);
    vecs[10] = mk(32'h40, 1, 32'h40, 32'h200, 1, 1, 32'h100, 6'h10, 1, 32'h100, 6'h10, 1, 32'h200, 16'd3);
    vecs[11] = mk(32'h40, 0, 32'h0,  32'h0,   0, 0, 32'h0,   6'h00, 1, 32'h200, 6'h10, 0, 32'h4,   16'd4);
    vecs[12] = mk(32'h80, 0, 32'h0,  32'h0,   0, 0, 32'h0,   6'h00, 0, 32'h84,  6'h20, 0, 32'h4,   16'd4);
    vecs[13] = mk(32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0, 0, 32'h0, 6'h00, 0, 32'h0, 6'h3F, 0, 32'h4,   16'd4);
    vecs[14] = mk(32'h104, 1, 32'h104, 32'h500, 0, 0, 32'h0, 6'h01, 0, 32'h108, 6'h01, 0, 32'h108, 16'd4);
    vecs[15] = mk(32'h104, 0, 32'h0,  32'h0,  0, 0, 32'h0,   6'h00, 0, 32'h108, 6'h01, 0, 32'h4,   16'd4);
    rst = 1;
    drive(mk(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_count", 32'(mispredict_count), 32'd0);
    chk("reset_pred_taken", 32'(pred_taken), 32'd0);
    chk("reset_wrong", 32'(pridictor_wrong), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
      chk($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_tgt);
      chk($sformatf("v%0d_pred_index", i), 32'(pred_index), 32'(vecs[i].e_idx));
      chk($sformatf("v%0d_wrong", i), 32'(pridictor_wrong), 32'(vecs[i].e_wrong));
      chk($sformatf("v%0d_correct_pc", i), correct_pc, vecs[i].e_cpc);
      chk($sformatf("v%0d_count", i), 32'(mispredict_count), 32'(vecs[i].e_cnt));
      @(posedge clk);
      #1;
    end
    drive(mk(32'h40, 1, 32'h40, 32'h100, 0, 1, 32'h100, 6'h10, 0, 0, 0, 0, 0, 0));
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("sat_count", 32'(mispredict_count), 32'hFFFF);
    chk("sat_wrong", 32'(pridictor_wrong), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("sat_hold", 32'(mispredict_count), 32'hFFFF);
    rst = 1;
    drive(mk(32'h40, 1, 32'h40, 32'h200, 1, 0, 32'h0, 6'h10, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    chk("rst_wrong_masked", 32'(pridictor_wrong), 32'd0);
    chk("rst_count_clear", 32'(mispredict_count), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    drive(mk(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("post_rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("post_rst_pred_target", pred_target, 32'h44);
    chk("post_rst_count", 32'(mispredict_count), 32'd0);
    drive(mk(32'h40, 1, 32'h40, 32'h100, 1, 1, 32'h100, 6'h10, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 drive(mk(32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("post_rst_wnt_to_wt", 32'(pred_taken), 32'd1);
    chk("post_rst_no_count", 32'(mispredict_count), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL: if_pc  in  32  fetch-stage PC to predict.
REQ-004 SHALL: pred_taken  out  1  combinational taken prediction for if_pc.
REQ-005 SHALL: pred_target  out  32  predicted next PC for if_pc.
REQ-006 SHALL: pred_index  out  6  BHT index used for if_pc; carried down the pipeline.
REQ-007 SHALL: ex_branch_valid  in  1  a branch resolves in EX this cycle.
REQ-008 SHALL: ex_pc / ex_target  in  32 each  resolved branch PC / actual target.
REQ-009 SHALL: ex_taken  in  1  actual outcome.
REQ-010 SHALL: ex_pred_taken / ex_pred_target / ex_pred_index  in  1/32/6  prediction carried with that branch.
REQ-011 SHALL: pridictor_wrong  out  1  misprediction flag, feeds the hazard detector and IF/ID flush.
REQ-012 SHALL: correct_pc  out  32  redirect PC, valid when pridictor_wrong=1.
REQ-013 SHALL: mispredict_count  out  16  saturating count of mispredictions.

Function
REQ-014 SHALL: BHT = 64 x 2-bit saturating counters, encoding 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-015 SHALL: BTB = 16 direct-mapped entries {valid, tag=pc[31:6], target[31:0]}, index pc[5:2].
REQ-016 SHALL: pred_taken=1 only if BTB hit (valid, tag match) and BHT[pred_index][1]=1; pred_target = BTB target when pred_taken, else if_pc+4 (mod 2^32).
REQ-017 SHALL: pred_* are combinational from if_pc and current state; zero-cycle latency.
REQ-018 SHALL: pridictor_wrong = ex_branch_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)), combinational.
REQ-019 SHALL: correct_pc = ex_taken ? ex_target : ex_pc+4.
REQ-020 SHALL: on edge with ex_branch_valid: BHT[ex_pred_index] increments if taken, decrements if not, saturating at 11/00.
REQ-021 SHALL: on edge with ex_branch_valid & ex_taken: BTB[ex_pc[5:2]] <= {1, ex_pc[31:6], ex_target}; not-taken leaves BTB unchanged.
REQ-022 SHALL: mispredict_count increments on each edge with pridictor_wrong=1; holds at 0xFFFF.
REQ-023 SHALL: same-cycle fetch read and EX write of one entry: prediction uses pre-update value; new value visible next cycle.
REQ-024 SHALL: ex_branch_valid=0 leaves all state unchanged; fetch stalls need no input (prediction re-evaluates on held if_pc).

Reset
REQ-025 SHALL: rst=1 at an edge sets all BHT counters to 01, all BTB valid to 0, mispredict_count to 0, history (if present) to 0.
REQ-026 SHALL: while rst=1, pridictor_wrong=0 and no update occurs, even if ex_branch_valid=1.
REQ-027 SHALL: after reset, pred_taken=0 and pred_target=if_pc+4 for every PC.

Configuration
REQ-028 SHALL: macro GSHARE_PREDICTOR_EN defined -> 6-bit global history register; pred_index = if_pc[7:2] XOR ghr; at each resolve edge ghr <= {ghr[4:0], ex_taken}.
REQ-029 SHALL: macro undefined -> no history register; pred_index = if_pc[7:2]; all else identical.

Structure
REQ-030 SHALL: shared package holds BHT_ENTRIES=64, BHT_IDX_W=6, BTB_ENTRIES=16, BTB_TAG_W=26, and the 2-bit counter encodings.
REQ-031 SHALL: BTB implemented as one sub-module, btb_table (async read, sync write, sync clear).

Verification
REQ-032 SHALL: after reset, if_pc=0x0000_0040 -> pred_taken=0, pred_target=0x0000_0044, pred_index=0x10 (no GSHARE).
REQ-033 SHALL: resolve ex_pc=0x40 taken to 0x100 twice (ex_pred_taken=0) -> pridictor_wrong=1 both cycles, correct_pc=0x100; then if_pc=0x40 -> pred_taken=1, pred_target=0x100.
REQ-034 SHALL: four more taken resolves of 0x40 -> counter holds 11; one not-taken -> 10, still predicts taken.
REQ-035 SHALL: ex_pred_taken=1, ex_taken=1, ex_target=0x200, ex_pred_target=0x100 -> pridictor_wrong=1, correct_pc=0x200, BTB target becomes 0x200.
REQ-036 SHALL: ex_branch_valid=1 mispredicted with rst=1 -> pridictor_wrong=0, mispredict_count=0, BHT unchanged; 0xFFFF+1 mispredicts -> count stays 0xFFFF.
